mc_accumulator: RTL
===================

MC_ACCUMULATOR -- requirements
Module: mc_accumulator

Interface
REQ-001 SHALL have parameter NETWORK_SIZE, default 256, the number of neurons; IN_W = $clog2(NETWORK_SIZE).
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default 32, the signed data and bias width.
REQ-003 SHALL have parameter NUM_CH, default 4, the number of independent neuron channels; CH_W = max(1,$clog2(NUM_CH)).
REQ-004 SHALL have parameter OUT_WIDTH, default 32, the signed result width, with OUT_WIDTH <= IN_W+PAYLOAD_WIDTH.
REQ-005 SHALL have parameter SATURATE, default 1: 1 = clamp the result to OUT_WIDTH, 0 = truncate it.
REQ-006 SEQ_WIDTH = $clog2($sqrt(NETWORK_SIZE)*2); ACC_W = IN_W+PAYLOAD_WIDTH.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 Ports, as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- MUL_ACC_valid  in  1  input packet valid
- MUL_ACC_type  in  3  packet type
- MUL_ACC_seqNum  in  SEQ_WIDTH  sequence number
- MUL_ACC_chan  in  CH_W  target channel
- MUL_ACC_inputNum  in  IN_W  input count (config) / index (data)
- MUL_ACC_data  in  PAYLOAD_WIDTH  product or bias
- MUL_ACC_halt  out  1  backpressure to the upstream stage
- ACC_AF_halt  in  1  backpressure from the downstream stage
- ACC_AF_valid  out  1  output packet valid
- ACC_AF_type  out  3  packet type
- ACC_AF_seqNum  out  SEQ_WIDTH  sequence number
- ACC_AF_chan  out  CH_W  channel
- ACC_AF_data  out  ACC_W  result or pass-through payload
- err_drop  out  1  sticky flag: a DATA packet was dropped

Function
REQ-009 SHALL contain one stage register holding valid, type, seqNum, chan, inputNum and data.
REQ-010 SHALL keep per-channel state: bias[PAYLOAD_WIDTH], target[IN_W], counter[IN_W] and partial[ACC_W].
REQ-011 Type encodings: DATA=3'b000, CONF_INB=3'b001; all other types are pass-through.
REQ-012 emit = stage valid AND (type!=DATA OR (channel legal AND target!=0 AND counter+1==target)).
REQ-013 The stage SHALL be consumed when stage valid AND NOT (emit AND ACC_AF_halt).
- A non-emitting DATA packet is never stalled.
REQ-014 MUL_ACC_halt = stage valid AND emit AND ACC_AF_halt (combinational).
- The stage register loads the input whenever MUL_ACC_halt is low.
REQ-015 ACC_AF_valid = emit; type, seqNum and chan SHALL mirror the stage register.
REQ-016 Latency: a packet accepted at edge N SHALL appear on ACC_AF_* during the cycle after edge N.
- Its output SHALL hold stable while ACC_AF_halt is high.
REQ-017 CONF_INB on consume SHALL load bias[chan]=data and target[chan]=inputNum.
- It SHALL clear counter[chan] and partial[chan], discarding any partial sum in progress.
- It SHALL be forwarded with ACC_AF_data = {inputNum, data}.
REQ-018 A pass-through type SHALL be forwarded with ACC_AF_data = {inputNum, data} and SHALL change no channel state.
REQ-019 DATA: sum = (counter==0 ? sext(bias) : partial) + sext(data), computed in ACC_W bits.
REQ-020 DATA, not emitting, on consume: partial=sum and counter=counter+1.
REQ-021 DATA, emitting, on consume: counter=0.
- ACC_AF_data = sext(clamp_or_truncate(sum, OUT_WIDTH)).
REQ-022 SATURATE=1: sum > 2^(OUT_WIDTH-1)-1 SHALL give the maximum value; sum < -2^(OUT_WIDTH-1) SHALL give the minimum value.
REQ-023 With target==1, the first DATA packet SHALL emit bias+data immediately.
REQ-024 A DATA packet with chan>=NUM_CH or target[chan]==0 SHALL be dropped and set err_drop.
- A dropped packet produces no output and changes no state.
- err_drop clears only on reset.
REQ-025 Channels SHALL be fully independent; interleaved DATA to different channels SHALL accumulate separately.

Reset
REQ-026 While rst is low, the stage valid flag, all per-channel state and err_drop SHALL be 0.
- ACC_AF_valid=0, MUL_ACC_halt=0, ACC_AF_data=0.
REQ-027 Reset asserted mid-accumulation SHALL discard all partials; it takes effect asynchronously.
REQ-028 Release is synchronous to clk; the first packet is accepted at the first edge after release.

Verification
REQ-029 CONF_INB ch0 bias=10 inputNum=3, then DATA 1,2,3 -> exactly one output, 16, one cycle after the third DATA.
REQ-030 ch0 target=2 bias=0 and ch1 target=2 bias=100, then DATA ch0 5, ch1 7, ch0 6, ch1 8 -> outputs ch0=11 then ch1=115.
REQ-031 OUT_WIDTH=8, SATURATE=1, target=2, DATA 100,100 -> 127; the same with DATA -100,-100 -> -128; SATURATE=0 gives the truncated value.
REQ-032 ACC_AF_halt held high for 3 cycles on an emitting packet -> output stable and MUL_ACC_halt high for 3 cycles; non-emitting DATA before it is never stalled.
REQ-033 DATA to an unconfigured channel -> no output, err_drop=1; a CONF_INB mid-burst restarts the sum from the new bias.
REQ-034 rst pulsed low mid-burst -> all outputs 0 immediately; after reconfiguration the next burst sum is correct.

Source files
------------

// File: rtl/mc_accumulator.sv
// Multi-channel neuron accumulator: sums per-channel DATA products onto a bias and emits
// one clamped or truncated result per burst; other packet types pass straight through.
module mc_accumulator #(
  parameter int unsigned NETWORK_SIZE  = 256,
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned SATURATE      = 1,
  localparam int unsigned IN_W      = $clog2(NETWORK_SIZE),
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  // clog2(2*sqrt(N)) == 1 + ceil(clog2(N)/2)
  localparam int unsigned SEQ_WIDTH = 1 + ($clog2(NETWORK_SIZE) + 1) / 2,
  localparam int unsigned ACC_W     = IN_W + PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MUL_ACC_valid,
  input  logic [2:0]               MUL_ACC_type,
  input  logic [SEQ_WIDTH-1:0]     MUL_ACC_seqNum,
  input  logic [CH_W-1:0]          MUL_ACC_chan,
  input  logic [IN_W-1:0]          MUL_ACC_inputNum,
  input  logic [PAYLOAD_WIDTH-1:0] MUL_ACC_data,
  output logic                     MUL_ACC_halt,
  input  logic                     ACC_AF_halt,
  output logic                     ACC_AF_valid,
  output logic [2:0]               ACC_AF_type,
  output logic [SEQ_WIDTH-1:0]     ACC_AF_seqNum,
  output logic [CH_W-1:0]          ACC_AF_chan,
  output logic [ACC_W-1:0]         ACC_AF_data,
  output logic                     err_drop
);

  localparam logic [2:0] TypeData    = 3'b000;
  localparam logic [2:0] TypeConfInb = 3'b001;

  localparam logic signed [ACC_W-1:0] OutMax = ACC_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OutMin = ~OutMax;

  logic                            stage_valid_q;
  logic [2:0]                      stage_type_q;
  logic [SEQ_WIDTH-1:0]            stage_seq_q;
  logic [CH_W-1:0]                 stage_chan_q;
  logic [IN_W-1:0]                 stage_in_q;
  logic signed [PAYLOAD_WIDTH-1:0] stage_data_q;

  logic signed [PAYLOAD_WIDTH-1:0] bias_q    [NUM_CH];
  logic [IN_W-1:0]                 target_q  [NUM_CH];
  logic [IN_W-1:0]                 counter_q [NUM_CH];
  logic signed [ACC_W-1:0]         partial_q [NUM_CH];
  logic                            err_drop_q;

  logic                     chan_legal, is_data, is_conf, data_ok, last, emit, consume;
  logic [CH_W-1:0]          ch_idx;
  logic [IN_W-1:0]          cur_target, cur_count;
  logic signed [ACC_W-1:0]  sum, result;
  logic signed [OUT_WIDTH-1:0] res_trunc;

  always_comb begin
    chan_legal = 32'(stage_chan_q) < NUM_CH;
    ch_idx     = chan_legal ? stage_chan_q : '0;
    is_data    = stage_type_q == TypeData;
    is_conf    = stage_type_q == TypeConfInb;
    cur_target = target_q[ch_idx];
    cur_count  = counter_q[ch_idx];
    data_ok    = chan_legal && (cur_target != '0);
    last       = (cur_count + 1'b1) == cur_target;
    emit       = stage_valid_q && (!is_data || (data_ok && last));
    consume    = stage_valid_q && !(emit && ACC_AF_halt);

    // First product of a burst starts from the bias, later ones from the partial sum.
    sum = ((cur_count == '0) ? ACC_W'(bias_q[ch_idx]) : partial_q[ch_idx])
          + ACC_W'(stage_data_q);
    res_trunc = sum[OUT_WIDTH-1:0];
    if (SATURATE != 0 && sum > OutMax) begin
      result = OutMax;
    end else if (SATURATE != 0 && sum < OutMin) begin
      result = OutMin;
    end else begin
      result = ACC_W'(res_trunc);
    end
  end

  assign MUL_ACC_halt  = stage_valid_q && emit && ACC_AF_halt;
  assign ACC_AF_valid  = emit;
  assign ACC_AF_type   = stage_type_q;
  assign ACC_AF_seqNum = stage_seq_q;
  assign ACC_AF_chan   = stage_chan_q;
  assign ACC_AF_data   = is_data ? result : {stage_in_q, stage_data_q};
  assign err_drop      = err_drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_type_q  <= '0;
      stage_seq_q   <= '0;
      stage_chan_q  <= '0;
      stage_in_q    <= '0;
      stage_data_q  <= '0;
    end else if (!MUL_ACC_halt) begin
      stage_valid_q <= MUL_ACC_valid;
      stage_type_q  <= MUL_ACC_type;
      stage_seq_q   <= MUL_ACC_seqNum;
      stage_chan_q  <= MUL_ACC_chan;
      stage_in_q    <= MUL_ACC_inputNum;
      stage_data_q  <= MUL_ACC_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        bias_q[i]    <= '0;
        target_q[i]  <= '0;
        counter_q[i] <= '0;
        partial_q[i] <= '0;
      end
      err_drop_q <= 1'b0;
    end else if (consume) begin
      if (is_conf && chan_legal) begin
        bias_q[ch_idx]    <= stage_data_q;
        target_q[ch_idx]  <= stage_in_q;
        counter_q[ch_idx] <= '0;
        partial_q[ch_idx] <= '0;
      end else if (is_data && data_ok) begin
        if (emit) begin
          counter_q[ch_idx] <= '0;
        end else begin
          partial_q[ch_idx] <= sum;
          counter_q[ch_idx] <= cur_count + 1'b1;
        end
      end else if (is_data) begin
        err_drop_q <= 1'b1;
      end
    end
  end

endmodule
